// File: rtl/sprite_register_loader.sv
// Sprite register loader: host-writable shadow table of sprite attributes
// (x, y, shape, enable per sprite) copied to the sprite register-write bus as
// one contiguous burst at the start of vertical blank, or on a forced request.
module sprite_register_loader #(
   parameter int BASE_INDEX  = 0,
   parameter int NUM_SPRITES = 8,
   parameter int VBLANK_LINE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  raster_y,
   input  logic        host_write_i,
   input  logic [7:0]  host_addr_i,
   input  logic [15:0] host_data_i,
   input  logic        force_load_i,
   output logic        register_write_o,
   output logic [11:0] register_index_o,
   output logic [15:0] register_write_value_o,
   output logic        busy_o,
   output logic        load_done_o
);

   localparam int N  = 4 * NUM_SPRITES;
   localparam int AW = $clog2(N);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [15:0]     shadow [N];
   logic [15:0]     rd_data;
   logic [AW-1:0]   rd_addr;
   logic [AW-1:0]   k_q, k_nxt;
   logic            at_line_q;
   logic            vblank_edge;
   logic            dirty;
   logic            trigger;
   logic            wr_ok;
   logic            done_q;

   // Out-of-range host addresses are dropped entirely (no write, no dirty).
   assign wr_ok       = host_write_i && (32'(host_addr_i) < 32'(N));
   assign vblank_edge = (raster_y == 10'(VBLANK_LINE)) && !at_line_q;
   assign trigger     = (state == IDLE) && ((vblank_edge && dirty) || force_load_i);
   assign load_done_o = done_q;

   // Shadow RAM: one write port (host), one synchronous read port (burst).
   // Same-address collision returns the old word, so a write landing on the
   // word being read this cycle goes out on the next reload instead.
   always_ff @(posedge clk) begin
      if (wr_ok)
         shadow[host_addr_i[AW-1:0]] <= host_data_i;
      rd_data <= shadow[rd_addr];
   end

   // Control state, raster-line history, dirty flag and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k_q       <= '0;
         at_line_q <= 1'b0;
         dirty     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         k_q       <= k_nxt;
         at_line_q <= (raster_y == 10'(VBLANK_LINE));
         done_q    <= (state == DRAIN);
         // Burst start consumes dirty; a write in the same cycle re-arms it.
         if (state == FILL)
            dirty <= wr_ok;
         else if (wr_ok)
            dirty <= 1'b1;
      end
   end

   // Next-state and bus outputs; outputs are zero whenever no strobe is issued.
   always_comb begin
      state_nxt              = state;
      k_nxt                  = k_q;
      rd_addr                = '0;
      busy_o                 = 1'b0;
      register_write_o       = 1'b0;
      register_index_o       = '0;
      register_write_value_o = '0;
      case (state)
         IDLE: begin
            if (trigger)
               state_nxt = FILL;
         end
         FILL: begin
            busy_o    = 1'b1;
            rd_addr   = '0;
            k_nxt     = '0;
            state_nxt = STREAM;
         end
         STREAM: begin
            busy_o                 = 1'b1;
            register_write_o       = 1'b1;
            register_index_o       = 12'(BASE_INDEX) + 12'(k_q);
            register_write_value_o = rd_data;
            rd_addr                = k_q + AW'(1);
            k_nxt                  = k_q + AW'(1);
            if (k_q == AW'(N - 2))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            busy_o                 = 1'b1;
            register_write_o       = 1'b1;
            register_index_o       = 12'(BASE_INDEX) + 12'(k_q);
            register_write_value_o = rd_data;
            state_nxt              = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sprite_register_loader.sv
// Directed bench for sprite_register_loader: two instances share stimulus,
// one at BASE_INDEX 0 and one at 0x100; a negedge monitor logs bus writes.
module tb_sprite_register_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  raster_y = 10'd0;
   logic        host_write_i = 1'b0;
   logic [7:0]  host_addr_i = 8'd0;
   logic [15:0] host_data_i = 16'd0;
   logic        force_load_i = 1'b0;

   logic        w0, w1, b0, b1, d0, d1;
   logic [11:0] i0, i1;
   logic [15:0] v0, v1;

   sprite_register_loader #(.BASE_INDEX(0), .NUM_SPRITES(8), .VBLANK_LINE(480)) dut0 (
      .clk(clk), .reset(reset), .raster_y(raster_y),
      .host_write_i(host_write_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
      .force_load_i(force_load_i),
      .register_write_o(w0), .register_index_o(i0), .register_write_value_o(v0),
      .busy_o(b0), .load_done_o(d0));

   sprite_register_loader #(.BASE_INDEX(256), .NUM_SPRITES(8), .VBLANK_LINE(480)) dut1 (
      .clk(clk), .reset(reset), .raster_y(raster_y),
      .host_write_i(host_write_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
      .force_load_i(force_load_i),
      .register_write_o(w1), .register_index_o(i1), .register_write_value_o(v1),
      .busy_o(b1), .load_done_o(d1));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   logic [11:0] li0[$];
   logic [11:0] li1[$];
   logic [15:0] lv[$];
   int          lc[$];
   int          busy_n, done_n, done_cyc, idle_bad;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every strobe plus busy/done activity, sampled mid-cycle.
   always @(negedge clk) begin
      if (w0) begin
         li0.push_back(i0);
         li1.push_back(i1);
         lv.push_back(v0);
         lc.push_back(cyc);
      end else if (i0 != 12'd0 || v0 != 16'd0) begin
         idle_bad = idle_bad + 1;
      end
      if (b0) busy_n = busy_n + 1;
      if (d0) begin
         done_n   = done_n + 1;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      li0.delete(); li1.delete(); lv.delete(); lc.delete();
      busy_n = 0; done_n = 0; done_cyc = -1;
   endtask

   task automatic hwrite(input logic [7:0] a, input logic [15:0] d);
      host_write_i = 1'b1; host_addr_i = a; host_data_i = d;
      tick(1);
      host_write_i = 1'b0;
   endtask

   task automatic pulse_force();
      force_load_i = 1'b1;
      tick(1);
      force_load_i = 1'b0;
   endtask

   // Returns at the start of burst cycle k = n (n strobes already seen).
   task automatic wait_writes(input int n);
      int t = 0;
      while (li0.size() < n && t < 200) begin tick(1); t++; end
      if (li0.size() < n) chk("wait_writes_timeout", li0.size(), n);
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_n == 0 && t < 200) begin tick(1); t++; end
      if (done_n == 0) chk("wait_done_timeout", done_n, 1);
      tick(2);
   endtask

   // Full-burst shape: 32 contiguous strobes, both index maps, done right after.
   task automatic check_burst(input string tag);
      int bad_i0 = 0;
      int bad_i1 = 0;
      chk({tag, "_count"}, li0.size(), 32);
      if (li0.size() == 32) begin
         for (int k = 0; k < 32; k++) begin
            if (li0[k] != 12'(k)) bad_i0++;
            if (li1[k] != 12'(256 + k)) bad_i1++;
         end
         chk({tag, "_idx_base0"}, bad_i0, 0);
         chk({tag, "_idx_base100"}, bad_i1, 0);
         chk({tag, "_contig"}, lc[31] - lc[0], 31);
         chk({tag, "_done_after_last"}, done_cyc, lc[31] + 1);
      end
      chk({tag, "_done_cnt"}, done_n, 1);
      chk({tag, "_busy_cycles"}, busy_n, 33);
   endtask

   initial begin
      int bad_v;
      clear_log();
      idle_bad = 0;

      // Reset state
      tick(3);
      chk("rst_write", w0, 0);
      chk("rst_index", i0, 0);
      chk("rst_value", v0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_done", d0, 0);
      reset = 1'b0;
      raster_y = 10'd479;
      tick(1);

      // Fill the table; no vblank yet -> no writes
      hwrite(8'd0, 16'h0064);
      hwrite(8'd1, 16'h0032);
      hwrite(8'd2, 16'h0005);
      hwrite(8'd3, 16'h0001);
      for (int k = 4; k < 32; k++) hwrite(8'(k), 16'h1000 + 16'(k));
      tick(3);
      chk("pre_vblank_writes", li0.size(), 0);

      // 479 -> 480 with dirty table -> burst
      raster_y = 10'd480;
      wait_done();
      check_burst("vblank1");
      if (lv.size() == 32) begin
         chk("vb1_w0", lv[0], 16'h0064);
         chk("vb1_w1", lv[1], 16'h0032);
         chk("vb1_w2", lv[2], 16'h0005);
         chk("vb1_w3", lv[3], 16'h0001);
         bad_v = 0;
         for (int k = 4; k < 32; k++) if (lv[k] != 16'h1000 + 16'(k)) bad_v++;
         chk("vb1_rest", bad_v, 0);
      end

      // Held at 480 with clean table, then a fresh edge still clean
      clear_log();
      tick(50);
      chk("hold480_writes", li0.size(), 0);
      raster_y = 10'd479;
      tick(3);
      raster_y = 10'd480;
      tick(50);
      chk("clean_edge_writes", li0.size(), 0);
      chk("clean_edge_busy", busy_n, 0);

      // Forced load on a clean table; second force mid-burst is dropped
      clear_log();
      pulse_force();
      wait_writes(3);
      pulse_force();
      wait_done();
      tick(10);
      check_burst("force");
      if (lv.size() == 32) chk("force_w31", lv[31], 16'h101F);

      // Host writes during a burst: word 31 ahead of the read, word 0 behind it
      raster_y = 10'd479;
      clear_log();
      pulse_force();
      wait_writes(5);
      hwrite(8'd31, 16'hBEEF);
      wait_writes(10);
      hwrite(8'd0, 16'h1234);
      wait_done();
      chk("midwr_count", li0.size(), 32);
      if (lv.size() == 32) begin
         chk("midwr_w31_new", lv[31], 16'hBEEF);
         chk("midwr_w0_old", lv[0], 16'h0064);
         chk("midwr_w30", lv[30], 16'h101E);
      end
      clear_log();
      tick(2);
      raster_y = 10'd480;
      wait_done();
      check_burst("reload");
      if (lv.size() == 32) begin
         chk("reload_w0", lv[0], 16'h1234);
         chk("reload_w31", lv[31], 16'hBEEF);
      end

      // Reset in the middle of a burst
      raster_y = 10'd479;
      clear_log();
      pulse_force();
      wait_writes(12);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("midrst_write", w0, 0);
      chk("midrst_busy", b0, 0);
      tick(40);
      chk("midrst_done", done_n, 0);
      chk("midrst_count", li0.size(), 13);
      raster_y = 10'd480;
      tick(40);
      chk("postrst_vblank_writes", li0.size(), 13);

      // Out-of-range host address: no write, no dirty
      raster_y = 10'd479;
      clear_log();
      hwrite(8'hFF, 16'hDEAD);
      tick(3);
      raster_y = 10'd480;
      tick(40);
      chk("oob_no_burst", li0.size(), 0);
      pulse_force();
      wait_done();
      check_burst("oob_force");
      if (lv.size() == 32) begin
         chk("oob_w31_kept", lv[31], 16'hBEEF);
         chk("oob_w0_kept", lv[0], 16'h1234);
      end

      chk("idle_outputs_zero", idle_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
